// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state/size encodings and helpers for the byte-serialising memory controller.
package mem_ctrl_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam logic [31:0] DEF_IO_BASE = 32'h0003_0000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte count of an access; both 2'b10 and 2'b11 mean a full word.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves fetch and LSB requests over a byte-wide RAM/IO bus, one byte per cycle, little-endian.
// Build option MEM_CTRL_IO_STALL_EN: hold IO writes while io_buffer_full is high (ignored otherwise).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE = ADDR_WIDTH'(DEF_IO_BASE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_clear,
    input  logic                  in_fetch_ce,
    input  logic [ADDR_WIDTH-1:0] in_fetch_pc,
    output logic                  out_fetch_ce,
    output logic [DATA_WIDTH-1:0] out_fetch_instr,
    input  logic                  in_lsb_ce,
    input  logic                  in_lsb_wr,
    input  logic [ADDR_WIDTH-1:0] in_lsb_addr,
    input  logic [1:0]            in_lsb_size,
    input  logic [DATA_WIDTH-1:0] in_lsb_data,
    output logic                  out_lsb_ce,
    output logic [DATA_WIDTH-1:0] out_lsb_data,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    output logic [1:0]            dbg_state
);

    state_t state_q, state_d;

    logic                  fetch_pend_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic                  lsb_pend_q;
    logic                  lsb_wr_q;
    logic [ADDR_WIDTH-1:0] lsb_addr_q;
    logic [1:0]            lsb_size_q;
    logic [DATA_WIDTH-1:0] lsb_data_q;

    logic [ADDR_WIDTH-1:0] acc_addr_q;
    logic [2:0]            len_q;
    logic [1:0]            cnt_q;
    logic                  is_fetch_q;
    logic [DATA_WIDTH-1:0] rbuf_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  mem_wr_q;

    logic                  start_lsb, start_fetch, abort, last, stall;
    logic                  read_step, write_step;
    logic [1:0]            cnt_nxt;
    logic [ADDR_WIDTH-1:0] step_addr;
    logic [7:0]            next_byte;
    logic [DATA_WIDTH-1:0] rd_merged;

`ifdef MEM_CTRL_IO_STALL_EN
    assign stall = (state_q == ST_WRITE) && (mem_a >= IO_BASE) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign stall = FALSE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_lsb) begin
                    state_d = lsb_wr_q ? ST_WRITE : ST_READ;
                end else if (start_fetch) begin
                    state_d = ST_READ;
                end
            end
            ST_READ:  if (abort || last) state_d = ST_IDLE;
            ST_WRITE: if (!stall && last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // LSB beats fetch; a flush in the start cycle drops the pending fetch before it can start.
    always_comb begin
        start_lsb   = (state_q == ST_IDLE) && lsb_pend_q;
        start_fetch = (state_q == ST_IDLE) && !lsb_pend_q && fetch_pend_q && !in_clear;
        abort       = (state_q == ST_READ) && is_fetch_q && in_clear;
        last        = ({1'b0, cnt_q} == (len_q - 3'd1));
        read_step   = (state_q == ST_READ) && !abort;
        write_step  = (state_q == ST_WRITE) && !stall;
        cnt_nxt     = cnt_q + 2'd1;
        step_addr   = acc_addr_q + ADDR_WIDTH'(cnt_nxt);
        next_byte   = 8'(wdata_q >> {cnt_nxt, 3'b000});
        rd_merged   = rbuf_q | (DATA_WIDTH'(mem_din) << {cnt_q, 3'b000});
        mem_wr      = mem_wr_q & ~stall;
        dbg_state   = state_q;
    end

    // A new pulse wins over the clear, so a fetch arriving with in_clear is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pend_q <= FALSE;
            fetch_pc_q   <= '0;
            lsb_pend_q   <= FALSE;
            lsb_wr_q     <= FALSE;
            lsb_addr_q   <= '0;
            lsb_size_q   <= SZ_BYTE;
            lsb_data_q   <= ZERO_DATA;
        end else if (rdy) begin
            if (in_fetch_ce) begin
                fetch_pend_q <= TRUE;
                fetch_pc_q   <= in_fetch_pc;
            end else if (in_clear || start_fetch) begin
                fetch_pend_q <= FALSE;
            end
            if (in_lsb_ce) begin
                lsb_pend_q <= TRUE;
                lsb_wr_q   <= in_lsb_wr;
                lsb_addr_q <= in_lsb_addr;
                lsb_size_q <= in_lsb_size;
                lsb_data_q <= in_lsb_data;
            end else if (start_lsb) begin
                lsb_pend_q <= FALSE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_addr_q      <= '0;
            len_q           <= 3'd0;
            cnt_q           <= 2'd0;
            is_fetch_q      <= FALSE;
            rbuf_q          <= ZERO_DATA;
            wdata_q         <= ZERO_DATA;
            mem_wr_q        <= FALSE;
            mem_a           <= '0;
            mem_dout        <= 8'h00;
            out_fetch_ce    <= FALSE;
            out_fetch_instr <= ZERO_DATA;
            out_lsb_ce      <= FALSE;
            out_lsb_data    <= ZERO_DATA;
        end else if (rdy) begin
            out_fetch_ce <= FALSE;
            out_lsb_ce   <= FALSE;
            if (start_lsb) begin
                acc_addr_q <= lsb_addr_q;
                len_q      <= size_to_len(lsb_size_q);
                cnt_q      <= 2'd0;
                is_fetch_q <= FALSE;
                rbuf_q     <= ZERO_DATA;
                wdata_q    <= lsb_data_q;
                mem_a      <= lsb_addr_q;
                mem_wr_q   <= lsb_wr_q;
                mem_dout   <= lsb_data_q[7:0];
            end else if (start_fetch) begin
                acc_addr_q <= fetch_pc_q;
                len_q      <= 3'd4;
                cnt_q      <= 2'd0;
                is_fetch_q <= TRUE;
                rbuf_q     <= ZERO_DATA;
                mem_a      <= fetch_pc_q;
                mem_wr_q   <= FALSE;
            end else if (read_step) begin
                rbuf_q <= rd_merged;
                if (last) begin
                    if (is_fetch_q) begin
                        out_fetch_ce    <= TRUE;
                        out_fetch_instr <= rd_merged;
                    end else begin
                        out_lsb_ce   <= TRUE;
                        out_lsb_data <= rd_merged;
                    end
                end else begin
                    cnt_q <= cnt_nxt;
                    mem_a <= step_addr;
                end
            end else if (write_step) begin
                if (last) begin
                    mem_wr_q   <= FALSE;
                    out_lsb_ce <= TRUE;
                end else begin
                    cnt_q    <= cnt_nxt;
                    mem_a    <= step_addr;
                    mem_dout <= next_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model with a write log, hand-computed expectations.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        in_clear = 1'b0;
    logic        in_fetch_ce = 1'b0;
    logic [31:0] in_fetch_pc = '0;
    logic        out_fetch_ce;
    logic [31:0] out_fetch_instr;
    logic        in_lsb_ce = 1'b0;
    logic        in_lsb_wr = 1'b0;
    logic [31:0] in_lsb_addr = '0;
    logic [1:0]  in_lsb_size = 2'b00;
    logic [31:0] in_lsb_data = '0;
    logic        out_lsb_ce;
    logic [31:0] out_lsb_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic [1:0]  dbg_state;

    logic [7:0]  ram [0:1023];
    logic [39:0] wr_log[$];
    logic [39:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          fetch_pulses = 0;
    int          lsb_pulses = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_clear(in_clear),
        .in_fetch_ce(in_fetch_ce), .in_fetch_pc(in_fetch_pc),
        .out_fetch_ce(out_fetch_ce), .out_fetch_instr(out_fetch_instr),
        .in_lsb_ce(in_lsb_ce), .in_lsb_wr(in_lsb_wr), .in_lsb_addr(in_lsb_addr),
        .in_lsb_size(in_lsb_size), .in_lsb_data(in_lsb_data),
        .out_lsb_ce(out_lsb_ce), .out_lsb_data(out_lsb_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[9:0]];

    always @(posedge clk) begin
        if (mem_wr) begin
            wr_log.push_back({mem_a, mem_dout});
            if (mem_a < 32'd1024) ram[mem_a[9:0]] <= mem_dout;
        end
    end

    always @(negedge clk) begin
        if (out_fetch_ce) fetch_pulses++;
        if (out_lsb_ce) lsb_pulses++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pulse_fetch(input logic [31:0] pc);
        in_fetch_ce = 1'b1;
        in_fetch_pc = pc;
        @(negedge clk);
        in_fetch_ce = 1'b0;
    endtask

    task automatic pulse_lsb(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] data);
        in_lsb_ce   = 1'b1;
        in_lsb_wr   = wr;
        in_lsb_addr = addr;
        in_lsb_size = size;
        in_lsb_data = data;
        @(negedge clk);
        in_lsb_ce = 1'b0;
    endtask

    // Counts negedges until the chosen completion pulse is seen, bounded at 40.
    task automatic wait_ce(input bit lsb, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(lsb ? out_lsb_ce : out_fetch_ce) && n < 40);
    endtask

    task automatic run_fetch0(input string pfx);
        pulse_fetch(32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({pfx, "_mem_a"}, 40'(mem_a), 40'(k));
            check({pfx, "_ce_early"}, 40'(out_fetch_ce), 40'd0);
        end
        @(negedge clk);
        check({pfx, "_ce"}, 40'(out_fetch_ce), 40'd1);
        check({pfx, "_instr"}, 40'(out_fetch_instr), 40'h0000_0013);
        @(negedge clk);
        check({pfx, "_ce_one"}, 40'(out_fetch_ce), 40'd0);
    endtask

    initial begin
        int n;
        int p0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[0] = 8'h13;
        ram[4] = 8'h93; ram[5] = 8'h00; ram[6] = 8'h10; ram[7] = 8'h00;
        ram[8] = 8'hef; ram[9] = 8'hbe; ram[10] = 8'had; ram[11] = 8'hde;
        ram[32'h40] = 8'h37; ram[32'h41] = 8'h01;
        ram[32'h100] = 8'h34; ram[32'h101] = 8'h12;
        ram[32'h3ff] = 8'h5a;

        repeat (3) @(negedge clk);
        check("rst_mem_a", 40'(mem_a), 40'd0);
        check("rst_mem_wr", 40'(mem_wr), 40'd0);
        check("rst_fetch_ce", 40'(out_fetch_ce), 40'd0);
        check("rst_lsb_ce", 40'(out_lsb_ce), 40'd0);
        check("rst_state", 40'(dbg_state), 40'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // A request pulsed while frozen is ignored.
        rdy = 1'b0;
        pulse_fetch(32'h4);
        rdy = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("rdy_state", 40'(dbg_state), 40'(ST_IDLE));
        check("rdy_no_fetch", 40'(fetch_pulses), 40'd0);

        run_fetch0("s1");

        in_fetch_ce = 1'b1; in_fetch_pc = 32'h4;
        in_lsb_ce = 1'b1; in_lsb_wr = 1'b0; in_lsb_addr = 32'h100; in_lsb_size = 2'b01;
        @(negedge clk);
        in_fetch_ce = 1'b0; in_lsb_ce = 1'b0;
        wait_ce(1'b1, n);
        check("s2_lsb_lat", 40'(n), 40'd3);
        check("s2_lsb_data", 40'(out_lsb_data), 40'h0000_1234);
        check("s2_fetch_not_first", 40'(out_fetch_ce), 40'd0);
        wait_ce(1'b0, n);
        check("s2_fetch_lat", 40'(n), 40'd5);
        check("s2_fetch_instr", 40'(out_fetch_instr), 40'h0010_0093);

        pulse_lsb(1'b0, 32'h101, 2'b00, 32'h0);
        wait_ce(1'b1, n);
        check("lb_lat", 40'(n), 40'd2);
        check("lb_data", 40'(out_lsb_data), 40'h0000_0012);

        pulse_lsb(1'b0, 32'hffff_ffff, 2'b01, 32'h0);
        wait_ce(1'b1, n);
        check("wrap_lat", 40'(n), 40'd3);
        check("wrap_data", 40'(out_lsb_data), 40'h0000_135a);

        wr_log.delete();
        exp_q = {40'h00_0000_0200_dd, 40'h00_0000_0201_cc, 40'h00_0000_0202_bb, 40'h00_0000_0203_aa};
        pulse_lsb(1'b1, 32'h200, 2'b10, 32'haabb_ccdd);
        wait_ce(1'b1, n);
        check("s3_lat", 40'(n), 40'd5);
        check("s3_nwr", 40'(wr_log.size()), 40'd4);
        for (int k = 0; k < 4; k++) begin
            check("s3_wr", (k < wr_log.size()) ? wr_log[k] : 40'hx, exp_q.pop_front());
        end
        @(negedge clk);
        check("s3_wr_low", 40'(mem_wr), 40'd0);
        check("s3_ce_one", 40'(out_lsb_ce), 40'd0);
        pulse_lsb(1'b0, 32'h200, 2'b11, 32'h0);
        wait_ce(1'b1, n);
        check("lw_lat", 40'(n), 40'd5);
        check("lw_data", 40'(out_lsb_data), 40'haabb_ccdd);

        pulse_fetch(32'h8);
        @(negedge clk);
        @(negedge clk);
        check("s4_mem_a", 40'(mem_a), 40'h9);
        p0 = fetch_pulses;
        in_clear = 1'b1; in_fetch_ce = 1'b1; in_fetch_pc = 32'h40;
        @(negedge clk);
        in_clear = 1'b0; in_fetch_ce = 1'b0;
        check("s4_abort_idle", 40'(dbg_state), 40'(ST_IDLE));
        check("s4_no_ce", 40'(out_fetch_ce), 40'd0);
        wait_ce(1'b0, n);
        check("s4_lat", 40'(n), 40'd5);
        check("s4_instr", 40'(out_fetch_instr), 40'h0000_0137);
        @(negedge clk);
        #1;
        check("s4_pulses", 40'(fetch_pulses - p0), 40'd1);

        wr_log.delete();
        io_buffer_full = 1'b1;
        pulse_lsb(1'b1, 32'h0003_0000, 2'b00, 32'h0000_005a);
`ifdef MEM_CTRL_IO_STALL_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s5_stall_wr", 40'(mem_wr), 40'd0);
            check("s5_stall_ce", 40'(out_lsb_ce), 40'd0);
        end
        io_buffer_full = 1'b0;
        #1;
        check("s5_resume_wr", 40'(mem_wr), 40'd1);
        wait_ce(1'b1, n);
        check("s5_lat", 40'(n), 40'd1);
`else
        @(negedge clk);
        check("s5_wr", 40'(mem_wr), 40'd1);
        check("s5_mem_a", 40'(mem_a), 40'h3_0000);
        wait_ce(1'b1, n);
        check("s5_lat", 40'(n), 40'd1);
        io_buffer_full = 1'b0;
`endif
        check("s5_nwr", 40'(wr_log.size()), 40'd1);
        check("s5_wr_byte", (wr_log.size() > 0) ? wr_log[0] : 40'hx, 40'h00_0003_0000_5a);

        pulse_lsb(1'b1, 32'h300, 2'b10, 32'h1122_3344);
        @(negedge clk);
        @(negedge clk);
        check("s6_wr_busy", 40'(mem_wr), 40'd1);
        p0 = lsb_pulses;
        rst = 1'b1;
        @(negedge clk);
        check("s6_rst_wr", 40'(mem_wr), 40'd0);
        check("s6_rst_lsb_ce", 40'(out_lsb_ce), 40'd0);
        check("s6_rst_fetch_ce", 40'(out_fetch_ce), 40'd0);
        check("s6_rst_state", 40'(dbg_state), 40'(ST_IDLE));
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("s6_no_done", 40'(lsb_pulses - p0), 40'd0);
        @(negedge clk);
        run_fetch0("s6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
